// File: rtl/trolley_system_button_pio.sv
// Avalon-MM input PIO for trolley push-buttons and limit switches: synchroniser,
// per-bit debounce, sticky edge capture with W1C, and a maskable level/edge interrupt.
module trolley_system_button_pio #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_MODE        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    cnt    [WIDTH];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata carry meaning.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    if (EDGE_TYPE == 0)      edge_event = stable & ~prev;
    else if (EDGE_TYPE == 1) edge_event = ~stable & prev;
    else                     edge_event = stable ^ prev;
  end

  assign wr_en    = chipselect && !write_n;
  assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = sync;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      default: rd_mux[WIDTH-1:0] = edge_capture;
    endcase
  end

  // New events are OR-ed in after the clear so a simultaneous set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      prev         <= stable;
      edge_capture <= (edge_capture & ~clr_mask) | edge_event;
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      readdata     <= rd_mux;
    end
  end

  assign irq = (IRQ_MODE == 1) ? |(edge_capture & irq_mask) : |(stable & irq_mask);

endmodule

// File: tb/tb_trolley_system_button_pio.sv
// Scoreboard bench: three PIO variants share one bus; a window-based debounce model
// predicts readdata and irq, and a monitor compares them every cycle.
module tb_trolley_system_button_pio;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int HL = SS + DB;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] pins = '0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trolley_system_button_pio #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .EDGE_TYPE(0), .IRQ_MODE(1)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  trolley_system_button_pio #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .EDGE_TYPE(1), .IRQ_MODE(1)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));

  trolley_system_button_pio #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .EDGE_TYPE(2), .IRQ_MODE(0)) dut_any_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  typedef struct {
    int          k;
    logic [31:0] rd;
    logic        irq;
  } exp_t;
  exp_t sb[$];

  int edge_sel [3] = '{0, 1, 2};
  int irq_sel  [3] = '{1, 1, 0};

  logic [W-1:0] hist [HL];
  logic [W-1:0] m_stable [3];
  logic [W-1:0] m_prev [3];
  logic [W-1:0] m_cap [3];
  logic [W-1:0] m_mask;

  // A level is accepted once every sample in the last DB synchronised cycles differs from it.
  function automatic logic [W-1:0] debounced(input logic [W-1:0] cur);
    logic [W-1:0] nxt;
    bit all_new;
    nxt = cur;
    for (int b = 0; b < W; b++) begin
      all_new = 1'b1;
      for (int i = SS; i < HL; i++) if (hist[i][b] == cur[b]) all_new = 1'b0;
      if (all_new) nxt[b] = ~cur[b];
    end
    return nxt;
  endfunction

  task automatic model_step();
    logic [W-1:0] ev, clr, sel;
    logic         wr;
    exp_t         e;
    if (!reset_n) begin
      for (int i = 0; i < HL; i++) hist[i] = '0;
      for (int k = 0; k < 3; k++) begin
        m_stable[k] = '0; m_prev[k] = '0; m_cap[k] = '0;
      end
      m_mask = '0;
      return;
    end
    for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = in_port;
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int k = 0; k < 3; k++) begin
      case (address)
        2'd0:    sel = m_stable[k];
        2'd1:    sel = hist[SS];
        2'd2:    sel = m_mask;
        default: sel = m_cap[k];
      endcase
      e.k  = k;
      e.rd = {{(32-W){1'b0}}, sel};
      if (edge_sel[k] == 0)      ev = m_stable[k] & ~m_prev[k];
      else if (edge_sel[k] == 1) ev = ~m_stable[k] & m_prev[k];
      else                       ev = m_stable[k] ^ m_prev[k];
      m_cap[k]    = (m_cap[k] & ~clr) | ev;
      m_prev[k]   = m_stable[k];
      m_stable[k] = debounced(m_stable[k]);
      sb.push_back(e);
    end
    if (wr && address == 2'd2) m_mask = writedata[W-1:0];
    for (int j = sb.size() - 3; j < sb.size(); j++) begin
      int k;
      k = sb[j].k;
      sb[j].irq = (irq_sel[k] == 1) ? |(m_cap[k] & m_mask) : |(m_stable[k] & m_mask);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  function automatic logic [31:0] dut_rd(input int k);
    return (k == 0) ? rd0 : (k == 1) ? rd1 : rd2;
  endfunction

  function automatic logic dut_irq(input int k);
    return (k == 0) ? irq0 : (k == 1) ? irq1 : irq2;
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk);
    while (reset_n && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut_rd(e.k) !== e.rd) begin
        failures++;
        $display("FAIL readdata inst%0d: got %h expected %h at %0t", e.k, dut_rd(e.k), e.rd, $time);
      end
      checks++;
      if (dut_irq(e.k) !== e.irq) begin
        failures++;
        $display("FAIL irq inst%0d: got %b expected %b at %0t", e.k, dut_irq(e.k), e.irq, $time);
      end
    end
  end

  task automatic cyc(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    in_port    = pins;
  endtask

  task automatic rd(input logic [1:0] a, input int n);
    repeat (n) cyc(1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    in_port = pins;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_rd(k) !== 32'h0 || dut_irq(k) !== 1'b0) begin
        failures++;
        $display("FAIL reset_state inst%0d: readdata %h irq %b, required 0/0", k, dut_rd(k), dut_irq(k));
      end
    end
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    rd(0, 1); rd(2, 1); rd(3, 1);

    // clean press of bit 0 with bit 0 unmasked
    wr(2, 32'h1);
    pins = 4'b0001;
    rd(0, 8);
    rd(3, 3);

    // bounce on bit 1, then a held press
    for (int r = 0; r < 5; r++) begin
      pins[1] = 1'b1; rd(3, 3);
      pins[1] = 1'b0; rd(0, 1);
    end
    pins[1] = 1'b1;
    rd(3, 10);

    // W1C, then a clear colliding with a fresh rise on bit 1
    wr(3, 32'h1); rd(3, 2);
    wr(3, 32'h2); rd(3, 1);
    pins = 4'b0001; rd(3, 10);
    pins = 4'b0011; rd(3, 6);
    wr(3, 32'h2);
    rd(3, 3);

    // mask gating on bit 3
    wr(3, 32'hF);
    wr(2, 32'h7);
    pins = 4'b1011; rd(3, 10);
    wr(2, 32'h8); rd(3, 2);
    wr(3, 32'h8); rd(3, 3);

    // level-mode tracking and release/press capture on bit 0
    wr(2, 32'h1);
    pins = 4'b0000; rd(0, 10);
    pins = 4'b0001; rd(0, 10);
    pins = 4'b0000; rd(3, 10);

    // inputs held through a mid-run reset are re-accepted
    pins = 4'b1111; rd(0, 3);
    do_reset();
    rd(0, 1); rd(2, 1); rd(3, 1);
    rd(0, 8); rd(3, 3);

    for (int n = 0; n < 600; n++) begin
      int op;
      if ($urandom_range(0, 11) == 0) pins[$urandom_range(0, W - 1)] ^= 1'b1;
      op = $urandom_range(0, 9);
      case (op)
        0, 1: wr(2, $urandom);
        2:    wr(3, $urandom);
        3:    wr(2'($urandom_range(0, 1)), $urandom);
        4:    cyc(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
        default: rd(2'($urandom_range(0, 3)), 1);
      endcase
    end

    rd(0, 2);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
